add_sub_serial_p: RTL and testbench
===================================

Name: add_sub_serial_p

Overview:
Parametrised digit-serial adder/subtractor, the successor to the 8-bit bit-serial adder. Latches two WIDTH-bit operands on a start request, then processes DIGIT bits per cycle, least-significant digit first, through a single DIGIT-bit adder slice with a carry register. It adds add/subtract mode, carry-out and signed-overflow flags, busy/done handshake and back-to-back operation. It sits in the datapath wherever an area-cheap multi-cycle adder is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2 and a multiple of DIGIT.
DIGIT, 1, bits processed per cycle; legal values 1..WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
en  input  1  start request; sampled only in IDLE or DONE.
sub  input  1  mode, sampled with en: 0 = a+b, 1 = a−b.
a  input  WIDTH  operand A, sampled with en.
b  input  WIDTH  operand B, sampled with en.
out  output  WIDTH  result; valid while done=1, held until next accepted start.
cout  output  1  carry out of MSB (sub: 1 = no borrow).
ovf  output  1  two's-complement signed overflow.
busy  output  1  high in ADD.
done  output  1  high for exactly the one cycle spent in DONE.

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-operation): state=IDLE; out, cout, ovf, busy, done, carry, count and operand registers all cleared to 0. Any operation in progress is abandoned and produces no done pulse.
- N = WIDTH/DIGIT. count is $clog2(N)+1 bits wide and counts 0..N-1.
- States: IDLE, ADD, DONE (encoding at implementer's choice).
- IDLE, en=1: a_reg←a; b_reg←(sub ? ~b : b); carry←sub; count←0; out←0; go to ADD. With en=0, stay in IDLE with all registers held.
- ADD, each cycle:
  - {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
  - out←{s, out[WIDTH-1:DIGIT]}; a_reg and b_reg shift right by DIGIT; carry←c; count←count+1.
  - On the last digit (count=N-1): cout←c; ovf←(carry into bit WIDTH-1) XOR c, where the carry into bit WIDTH-1 is taken from inside the final slice; go to DONE.
- en is ignored in ADD, so a new request cannot disturb an operation in progress.
- DONE: done=1, busy=0.
  - en=1: accept a new operation exactly as in IDLE and go to ADD. This supports back-to-back operation with one bubble cycle.
  - en=0: go to IDLE.
- out, cout and ovf hold their values through DONE and IDLE until the next start is accepted.
- Latency: start accepted at edge k → done=1 in the cycle after edge k+N. Throughput is one result per N+1 cycles.
- Width rule: arithmetic is modulo 2^WIDTH; cout and ovf are the only report of the extra bit.
- Input changes on a, b or sub after acceptance have no effect on the running operation.

Test Plan:
- WIDTH=8, DIGIT=1: en=1, a=100, b=27, sub=0 → busy for 8 cycles, then done=1 for one cycle with out=127, cout=0, ovf=0.
- WIDTH=8, DIGIT=1: a=200, b=100, sub=0 → out=44, cout=1, ovf=0. Then a=127, b=1 → out=0x80, cout=0, ovf=1.
- WIDTH=8, DIGIT=1, sub=1: a=5, b=7 → out=0xFE, cout=0, ovf=0. Then a=0x80, b=1 → out=0x7F, cout=1, ovf=1.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, sub=0 → done in the 5th cycle after acceptance, out=0x0000, cout=1, ovf=0. Random 500-vector check against a golden a±b model, for both DIGIT=1 and DIGIT=4.
- Handshake: pulse en in the 3rd ADD cycle with different operands → ignored, original result unchanged. Hold en=1 in DONE → new operation starts, second done arrives N+1 cycles after the first.
- Reset: assert rst in the 4th ADD cycle → next cycle state=IDLE, all outputs 0, no done pulse. A fresh start then completes correctly.

Source files
------------

// File: rtl/add_sub_serial_p.sv
// Digit-serial adder/subtractor: latches two WIDTH-bit operands on start and
// resolves DIGIT bits per cycle, LSD first, through one adder slice plus carry.
module add_sub_serial_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned SW = DIGIT + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, a_d, b_d, out_d;
    logic             carry_q, carry_d;
    logic             cout_d, ovf_d, busy_d, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start, last;
    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] s;
    logic             c, c_msb;

    assign start = en && ((state == S_IDLE) || (state == S_DONE));
    assign last  = (cnt_q == LAST);

    // One DIGIT-bit slice; the carry into its top bit recovers the carry into bit WIDTH-1.
    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + SW'(carry_q);
    assign s     = slice[DIGIT-1:0];
    assign c     = slice[DIGIT];
    assign c_msb = s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (en) state_next = S_ADD;
            S_ADD:   if (last) state_next = S_DONE;
            S_DONE:  state_next = en ? S_ADD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and flag next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        out_d   = out;
        cout_d  = cout;
        ovf_d   = ovf;
        busy_d  = (state_next == S_ADD);
        done_d  = (state_next == S_DONE);

        if (start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            out_d   = '0;
        end else if (state == S_ADD) begin
            out_d   = WIDTH'({s, out} >> DIGIT);
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = c;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
                cout_d = c;
                ovf_d  = c_msb ^ c;
            end
        end
    end

    // Datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            out     <= out_d;
            cout    <= cout_d;
            ovf     <= ovf_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_add_sub_serial_p.sv
// Bench for add_sub_serial_p: an 8-bit/1-bit instance and a 16-bit/4-bit instance
// checked against a queue of expected results.
module tb_add_sub_serial_p;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en8, sub8, cout8, ovf8, busy8, done8;
    logic [7:0]  a8, b8, out8;
    logic        en16, sub16, cout16, ovf16, busy16, done16;
    logic [15:0] a16, b16, out16;

    add_sub_serial_p #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .en(en8), .sub(sub8), .a(a8), .b(b8),
        .out(out8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    add_sub_serial_p #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .en(en16), .sub(sub16), .a(a16), .b(b16),
        .out(out16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    typedef struct {
        logic [15:0] out;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Golden a +/- b for a w-bit datapath, via integer and signed arithmetic
    function automatic exp_t model(int w, longint a, longint b, logic s);
        exp_t   e;
        longint m, sa, sb, r;
        m      = longint'(1) << w;
        e.out  = 16'((s ? a - b + m : a + b) % m);
        e.cout = s ? (a >= b) : (a + b >= m);
        sa     = (a >= m / 2) ? a - m : a;
        sb     = (b >= m / 2) ? b - m : b;
        r      = s ? sa - sb : sa + sb;
        e.ovf  = (r < -(m / 2)) || (r >= m / 2);
        return e;
    endfunction

    function automatic exp_t mk(logic [15:0] o, logic c, logic v);
        exp_t e;
        e.out = o; e.cout = c; e.ovf = v;
        return e;
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
        en8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        q8.push_back(e);
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s, input exp_t e);
        en16 = 1'b1; a16 = a; b16 = b; sub16 = s;
        q16.push_back(e);
    endtask

    // Runs until done, scrambling inputs after acceptance; cyc counts cycles since the accepting edge
    task automatic wait8(output int cyc, output int nb, output logic ok);
        cyc = 0; nb = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            en8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            cyc++;
            if (busy8) nb++;
            if (done8) ok = 1'b1;
        end
    endtask

    task automatic wait16(output int cyc, output int nb, output logic ok);
        cyc = 0; nb = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            en16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
            cyc++;
            if (busy16) nb++;
            if (done16) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en8 = 1'b0; en16 = 1'b0;
        a8 = '0; b8 = '0; sub8 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out8, cout8, ovf8, busy8, done8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset8: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     out8, cout8, ovf8, busy8, done8);
        end
        n_checks++;
        if ({out16, cout16, ovf16, busy16, done16} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset16: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     out16, cout16, ovf16, busy16, done16);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed8();
        logic [7:0] ta[5] = '{8'd100, 8'd200, 8'd127, 8'd5, 8'h80};
        logic [7:0] tb[5] = '{8'd27, 8'd100, 8'd1, 8'd7, 8'd1};
        logic       ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] to[5] = '{8'd127, 8'd44, 8'h80, 8'hFE, 8'h7F};
        logic       tc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int cyc, nb; logic ok; exp_t e;
        for (int i = 0; i < 5; i++) begin
            start8(ta[i], tb[i], ts[i], mk(16'(to[i]), tc[i], tv[i]));
            wait8(cyc, nb, ok);
            e = q8.pop_front();
            n_checks++;
            if (!ok || cyc != 9 || nb != 8) begin
                n_fail++;
                $display("FAIL latency8[%0d]: got done=%b at cycle %0d busy %0d, want cycle 9 busy 8",
                         i, ok, cyc, nb);
            end
            n_checks++;
            if ({out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL result8[%0d]: got out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                         i, out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
            end
            @(negedge clk);
            n_checks++;
            if ({done8, busy8, out8, cout8, ovf8} !== {2'b00, e.out[7:0], e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL hold8[%0d]: got done=%b busy=%b out=%h, want done=0 busy=0 out=%h",
                         i, done8, busy8, out8, e.out[7:0]);
            end
        end
    endtask

    task automatic test_digit16();
        int cyc, nb; logic ok; exp_t e;
        start16(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        wait16(cyc, nb, ok);
        e = q16.pop_front();
        n_checks++;
        if (!ok || cyc != 5 || nb != 4) begin
            n_fail++;
            $display("FAIL latency16: got done=%b at cycle %0d busy %0d, want cycle 5 busy 4", ok, cyc, nb);
        end
        n_checks++;
        if ({out16, cout16, ovf16} !== {e.out, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL carry16: got out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                     out16, cout16, ovf16, e.out, e.cout, e.ovf);
        end
        start16(16'h7FFF, 16'hFFFF, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        wait16(cyc, nb, ok);
        e = q16.pop_front();
        n_checks++;
        if (!ok || {out16, cout16, ovf16} !== {e.out, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL ovf16: got done=%b out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                     ok, out16, cout16, ovf16, e.out, e.cout, e.ovf);
        end
    endtask

    task automatic test_ignore_en();
        int cyc; logic ok; exp_t e;
        start8(8'h33, 8'h11, 1'b0, mk(16'h0044, 1'b0, 1'b0));
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            en8 = (cyc == 3);
            if (cyc == 3) begin a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; end
            if (done8) ok = 1'b1;
        end
        en8 = 1'b0;
        e = q8.pop_front();
        n_checks++;
        if (!ok || cyc != 9 || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL ignore_en: got done=%b cycle=%0d out=%h cout=%b ovf=%b, want cycle 9 out=%h cout=%b ovf=%b",
                     ok, cyc, out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, nb; logic ok; exp_t e;
        start8(8'd10, 8'd20, 1'b0, mk(16'd30, 1'b0, 1'b0));
        wait8(cyc, nb, ok);
        e = q8.pop_front();
        n_checks++;
        if (!ok || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b out=%h, want out=%h", ok, out8, e.out[7:0]);
        end
        start8(8'd50, 8'd60, 1'b1, mk(16'hF6, 1'b0, 1'b0));
        wait8(cyc, nb, ok);
        e = q8.pop_front();
        n_checks++;
        if (!ok || cyc != 9 || nb != 8) begin
            n_fail++;
            $display("FAIL b2b_spacing: got done=%b %0d cycles after first done busy %0d, want 9 busy 8",
                     ok, cyc, nb);
        end
        n_checks++;
        if ({out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL b2b_second: got out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                     out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, nb, seen; logic ok; exp_t e;
        start8(8'd200, 8'd100, 1'b0, mk(16'd44, 1'b1, 1'b0));
        wait8(cyc, nb, ok);
        e = q8.pop_front();
        n_checks++;
        if (!ok || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL pre_reset: got done=%b out=%h cout=%b, want out=%h cout=%b",
                     ok, out8, cout8, e.out[7:0], e.cout);
        end
        start8(8'h55, 8'h22, 1'b0, mk(16'h77, 1'b0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            en8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out8, cout8, ovf8, busy8, done8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     out8, cout8, ovf8, busy8, done8);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_abandon: got %0d busy/done cycles after reset, want 0", seen);
        end
        e = q8.pop_front();
        start8(8'h55, 8'h22, 1'b0, mk(16'h77, 1'b0, 1'b0));
        wait8(cyc, nb, ok);
        e = q8.pop_front();
        n_checks++;
        if (!ok || cyc != 9 || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL post_reset: got done=%b cycle=%0d out=%h, want cycle 9 out=%h",
                     ok, cyc, out8, e.out[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, nb; logic ok; exp_t e;
        logic [7:0] ra8, rb8; logic [15:0] ra16, rb16; logic rs;
        for (int i = 0; i < 500; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom);
            start8(ra8, rb8, rs, model(8, longint'(ra8), longint'(rb8), rs));
            wait8(cyc, nb, ok);
            e = q8.pop_front();
            n_checks++;
            if (!ok || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL rand8[%0d] %h %s %h: got done=%b out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                         i, ra8, rs ? "-" : "+", rb8, ok, out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
            end
        end
        for (int i = 0; i < 500; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'($urandom);
            start16(ra16, rb16, rs, model(16, longint'(ra16), longint'(rb16), rs));
            wait16(cyc, nb, ok);
            e = q16.pop_front();
            n_checks++;
            if (!ok || {out16, cout16, ovf16} !== {e.out, e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL rand16[%0d] %h %s %h: got done=%b out=%h cout=%b ovf=%b, want out=%h cout=%b ovf=%b",
                         i, ra16, rs ? "-" : "+", rb16, ok, out16, cout16, ovf16, e.out, e.cout, e.ovf);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_digit16();
        test_ignore_en();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
